// File: rtl/timer_scheduler.sv
// Shared tick-based timeout engine: one delay counter time-shared between N_REQ requesters
// with round-robin arbitration; each owner receives a one-cycle done pulse on completion.
module timer_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CW    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_in,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] ticks,
  input  logic                abort,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic [CW-1:0]       remaining
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic             tick_q;

  logic             tick_stb;
  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    cand;
  logic [N_REQ-1:0] win_oh;
  logic [CW-1:0]    owner_ticks;
  logic             owner_req;

  assign tick_stb = tick_in & ~tick_q;

  // Round-robin search starting one past the last served index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = PW'((32'(ptr_q) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found    = 1'b1;
        win_idx      = cand;
        win_oh       = '0;
        win_oh[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    owner_ticks = '0;
    owner_req   = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == PW'(i)) begin
        owner_ticks = ticks[i*CW +: CW];
        owner_req   = req[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        rem_d   = '0;
        if (win_found) begin
          grant_d = win_oh;
          owner_d = win_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        rem_d = owner_ticks;
        if (owner_ticks == '0) begin
          done_d  = grant_q;
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Abandonment outranks a coincident final tick.
        if (abort || !owner_req) begin
          grant_d = '0;
          rem_d   = '0;
          ptr_d   = owner_q;
          state_d = StIdle;
        end else if (tick_stb && rem_q != '0) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == CW'(1)) begin
            done_d  = grant_q;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        grant_d = '0;
        rem_d   = '0;
        ptr_d   = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      rem_q   <= '0;
      ptr_q   <= PW'(N_REQ - 1);
      owner_q <= '0;
      tick_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      tick_q  <= tick_in;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: service-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_timer_scheduler;

  localparam int N  = 4;
  localparam int CW = 8;

  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_COUNT = 2;
  localparam int PH_DONE  = 3;

  logic            clk;
  logic            reset;
  logic            tick_in;
  logic [N-1:0]    req;
  logic [N*CW-1:0] tick_cfg;
  logic            abort;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic [CW-1:0]   remaining;

  int checks = 0;
  int errors = 0;
  int done_log[$];

  timer_scheduler #(.N_REQ(N), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_in   (tick_in),
    .req       (req),
    .ticks     (tick_cfg),
    .abort     (abort),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one service at a time, tracked as owner + ticks seen versus target.
  bit m_valid = 1'b0;
  int m_owner = -1;
  int m_phase = PH_IDLE;
  int m_k     = 0;
  int m_seen  = 0;
  int m_last  = N - 1;
  bit m_tprev = 1'b1;

  function automatic bit req_bit(input logic [N-1:0] r, input int i);
    return ((r >> i) & 1) != 0;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int d = 1; d <= N; d++) begin
      if (req_bit(r, (last + d) % N)) return (last + d) % N;
    end
    return -1;
  endfunction

  function automatic int slice_of(input logic [N*CW-1:0] t, input int i);
    logic [CW-1:0] s;
    s = CW'(t >> (i * CW));
    return int'(s);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b1;
      m_owner <= -1;
      m_phase <= PH_IDLE;
      m_last  <= N - 1;
      m_tprev <= 1'b1;
    end else begin
      m_tprev <= tick_in;
      case (m_phase)
        PH_IDLE: if (req != '0) begin
          m_owner <= pick(req, m_last);
          m_phase <= PH_LOAD;
        end
        PH_LOAD: begin
          m_k     <= slice_of(tick_cfg, m_owner);
          m_seen  <= 0;
          m_phase <= (slice_of(tick_cfg, m_owner) == 0) ? PH_DONE : PH_COUNT;
        end
        PH_COUNT: begin
          if (abort || !req_bit(req, m_owner)) begin
            m_owner <= -1;
            m_last  <= m_owner;
            m_phase <= PH_IDLE;
          end else if (tick_in && !m_tprev) begin
            m_seen <= m_seen + 1;
            if (m_seen + 1 == m_k) m_phase <= PH_DONE;
          end
        end
        default: begin
          m_owner <= -1;
          m_last  <= m_owner;
          m_phase <= PH_IDLE;
        end
      endcase
    end
  end

  function automatic logic [N-1:0] exp_grant();
    return (m_owner >= 0) ? N'(1 << m_owner) : '0;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_grant", 32'(grant), 32'(exp_grant()));
      chk("model_done", 32'(done), (m_phase == PH_DONE) ? 32'(exp_grant()) : 32'd0);
      chk("model_busy", 32'(busy), 32'(m_owner >= 0));
      chk("model_remaining", 32'(remaining),
          (m_phase == PH_COUNT) ? 32'(m_k - m_seen) : 32'd0);
    end
    for (int i = 0; i < N; i++) if (done[i] === 1'b1) done_log.push_back(i);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick_in = 1'b1;
    step(1);
    tick_in = 1'b0;
    step(1);
  endtask

  task automatic wait_done(input int idx, input int budget, input string name);
    for (int c = 0; c < budget; c++) begin
      if (done[idx] === 1'b1) break;
      tick_in = ~tick_in;
      step(1);
    end
    chk(name, 32'(done[idx]), 32'd1);
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int nd;

  initial begin
    reset = 1'b1; tick_in = 1'b1; req = '0; abort = 1'b0; tick_cfg = '0;
    step(3);
    reset = 1'b0;
    step(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick_in = 1'b0;
    step(1);

    // Single requester, 3 ticks.
    tick_cfg[0*CW +: CW] = 8'd3;
    req = 4'b0001;
    step(1);
    chk("t2_grant_load", 32'(grant), 32'h1);
    chk("t2_busy_load", 32'(busy), 32'd1);
    step(1);
    chk("t2_rem3", 32'(remaining), 32'd3);
    tick_pulse();
    chk("t2_rem2", 32'(remaining), 32'd2);
    tick_pulse();
    chk("t2_rem1", 32'(remaining), 32'd1);
    tick_in = 1'b1;
    step(1);
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_rem0", 32'(remaining), 32'd0);
    chk("t2_grant_in_done", 32'(grant), 32'h1);
    req = '0; tick_in = 1'b0;
    step(1);
    chk("t2_grant_after", 32'(grant), 32'd0);
    chk("t2_done_after", 32'(done), 32'd0);

    // Round robin with all requesters held, from a fresh reset.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < N; i++) tick_cfg[i*CW +: CW] = 8'd1;
    done_log.delete();
    req = 4'b1111;
    for (int c = 0; c < 200 && done_log.size() < 5; c++) begin
      tick_in = ~tick_in;
      step(1);
    end
    req = '0;
    chk("rr_count", 32'(done_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < done_log.size()) chk("rr_order", 32'(done_log[i]), 32'(rr_exp[i]));
    end
    tick_in = 1'b0;
    step(3);

    // Zero-tick delay completes without any tick.
    tick_cfg[2*CW +: CW] = 8'd0;
    req = 4'b0100;
    step(1);
    chk("t4_grant", 32'(grant), 32'h4);
    step(1);
    chk("t4_done", 32'(done), 32'h4);
    chk("t4_rem", 32'(remaining), 32'd0);
    req = '0;
    step(1);
    chk("t4_grant_after", 32'(grant), 32'd0);
    step(1);

    // Abort after 2 of 5 ticks; requester 3 pending.
    tick_cfg[1*CW +: CW] = 8'd5;
    tick_cfg[3*CW +: CW] = 8'd2;
    req = 4'b0010;
    step(1);
    chk("t5_grant1", 32'(grant), 32'h2);
    req = 4'b1010;
    step(1);
    tick_pulse();
    tick_pulse();
    chk("t5_rem3", 32'(remaining), 32'd3);
    nd = done_log.size();
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t5_abort_grant", 32'(grant), 32'd0);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_done", 32'(done), 32'd0);
    step(1);
    chk("t5_next_grant", 32'(grant), 32'h8);
    chk("t5_no_done", 32'(done_log.size()), 32'(nd));
    wait_done(3, 40, "t5_done3");
    req = 4'b0010;
    step(2);
    chk("t5_regrant1", 32'(grant), 32'h2);
    wait_done(1, 40, "t5_done1");
    req = '0;
    tick_in = 1'b0;
    step(3);

    // Final tick coinciding with request drop.
    tick_cfg[0*CW +: CW] = 8'd2;
    req = 4'b0001;
    step(2);
    tick_pulse();
    chk("t6_rem1", 32'(remaining), 32'd1);
    nd = done_log.size();
    tick_in = 1'b1; req = '0;
    step(1);
    chk("t6_drop_grant", 32'(grant), 32'd0);
    chk("t6_drop_done", 32'(done), 32'd0);
    tick_in = 1'b0;
    step(3);
    chk("t6_drop_nodone", 32'(done_log.size()), 32'(nd));

    // Reset with 4 ticks remaining.
    tick_cfg[2*CW +: CW] = 8'd6;
    req = 4'b0100;
    step(2);
    tick_pulse();
    tick_pulse();
    chk("t6_rem4", 32'(remaining), 32'd4);
    nd = done_log.size();
    reset = 1'b1;
    step(1);
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_rem", 32'(remaining), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    req = '0;
    step(1);
    reset = 1'b0;
    step(3);
    chk("t6_rst_nodone", 32'(done_log.size()), 32'(nd));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Shared timeout engine that runs one tick-based delay counter on behalf of several requesters (debouncers, LED sequencers, executor wait states). It time-shares the counter between them with round-robin arbitration. The engine is clocked by the system clock. Its timebase is a slow prescaler tap, sampled as a level and converted to single-cycle tick strobes; the tap is never used as a clock. Each requester gets a one-cycle `done` pulse after its programmed number of ticks.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `CW`, default 8: delay counter width in ticks.

Ports:
- `clk`, in, 1: system clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `tick_in`, in, 1: prescaler tap level (e.g. fast debounce tap); each rising edge is one tick.
- `req`, in, N_REQ: level request per requester; held high until `done` or abandoned.
- `ticks`, in, N_REQ*CW: delay per requester; requester i uses bits [i*CW +: CW].
- `abort`, in, 1: cancel the delay currently in progress.
- `grant`, out, N_REQ: one-hot owner of the counter; all zero when idle.
- `done`, out, N_REQ: one-cycle completion pulse to the owner.
- `busy`, out, 1: high whenever state is not IDLE.
- `remaining`, out, CW: ticks still to run for the current owner.

## Operation

- Tick detect: register `tick_d`; `tick_stb = tick_in & ~tick_d`.
  - `tick_d` resets to 1, so a tap already high at reset release produces no tick.
- Round-robin pointer `ptr`: the last served index, reset to N_REQ-1 so requester 0 has first priority.
  - The search starts at ptr+1 and wraps modulo N_REQ.
  - `ptr` is updated to the owner on completion and on abandonment.
- State IDLE:
  - Outputs `grant`=0 and `remaining`=0.
  - If any `req` is high, register the winner's one-hot in `grant` and go to LOAD.
- State LOAD:
  - Sample the winner's `ticks` slice into `remaining`.
  - Go to DONE if the slice is 0, otherwise go to RUN.
  - A `tick_stb` in this state is ignored.
- State RUN:
  - On `tick_stb`, decrement `remaining`.
  - On the strobe that takes `remaining` from 1 to 0, go to DONE.
  - Leave for IDLE with no `done` pulse if `abort`=1 or `req[owner]`=0. On that exit, `grant` and `remaining` clear and `ptr` takes the owner.
- State DONE:
  - `done[owner]`=1 for exactly this cycle; `grant` is still high.
  - Next state is IDLE, with `ptr` set to the owner.
- Persistent request: if `req[owner]` is still high after `done`, the requester is treated as a new request. It is re-served only after all other pending requesters, which gives periodic-timer behaviour.
- `ticks` is sampled only in LOAD; later changes do not affect the running count.
- Counter arithmetic:
  - Unsigned, CW bits.
  - `remaining` never wraps below 0.
  - Maximum delay is 2^CW-1 ticks.

## Timing

- Reset (synchronous, effective at the next edge): state IDLE, `grant`=0, `done`=0, `busy`=0, `remaining`=0, `ptr`=N_REQ-1, `tick_d`=1.
  - Reset mid-delay produces no `done` pulse.
- Request seen in IDLE at edge t:
  - `grant` and `busy` high from cycle t+1 (LOAD).
  - RUN from t+2.
- Delay of K>0 ticks: `done` is high in the cycle after the clock edge that samples the K-th `tick_stb` in RUN. `grant` drops one cycle after `done`.
- K=0: `done` is high at t+2, with no tick needed.
- Minimum spacing between two services is one IDLE cycle, so back-to-back `done` pulses are at least 3 cycles apart for K=0.
- Simultaneous events in RUN:
  - `abort` or `req` drop in the same cycle as the final tick: abandonment wins, no `done`.
  - `abort` in IDLE, LOAD or DONE: ignored.
- All outputs are registered.

## Test plan

- Reset with `tick_in` held high, then release → no tick counted; `grant`=0 and `remaining`=0 until a `req` arrives.
- `req[0]`=1 with `ticks[0]`=3, then 3 rising edges on `tick_in` → `grant`=0001 at t+1; `remaining` steps 3,2,1,0; one `done[0]` pulse after the 3rd edge; `grant` is 0 the next cycle.
- `req`=1111, all `ticks`=1, requests held → grant order 0,1,2,3,0; each completion gives one `done` pulse to the matching index.
- `ticks[2]`=0 with `req[2]`=1 → `done[2]` at t+2 without any tick; `remaining` stays 0.
- `ticks[1]`=5, assert `abort` after 2 ticks → return to IDLE with no `done`; with `req[1]` still high, the next grant goes to the next pending requester (or back to 1 if none is pending).
- Final tick coinciding with `req[owner]` falling; and `reset` asserted with `remaining`=4 → neither case produces a `done` pulse; all outputs return to their reset values.
